enc_pwm_ctrl: RTL and testbench
===============================

Name: enc_pwm_ctrl

Overview:
Three-channel controller that converts quadrature encoder motion into PWM duty cycle. Each channel synchronises its A/B inputs, decodes x4 quadrature steps, and keeps a saturating duty register. The duty is applied to a free-running PWM generator at period boundaries only, so duty changes never produce glitches. This block replaces the direct encoder-to-PWM path in the gfxdemo wrapper and drives pwm0..2 outputs.

Parameters:
CNT_W, 8, width of PWM counter and duty registers; PWM period = 2^CNT_W clk cycles
STEP, 1, duty increment/decrement per valid quadrature transition (1..2^CNT_W-1)
DUTY_INIT, 0, reset value of duty and shadow registers (0..2^CNT_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; 0 = reset asserted
enc0_a  input  1  channel 0 encoder A, asynchronous to clk
enc0_b  input  1  channel 0 encoder B, asynchronous to clk
enc1_a / enc1_b  input  1 each  channel 1 encoder A/B
enc2_a / enc2_b  input  1 each  channel 2 encoder A/B
pwm0_out / pwm1_out / pwm2_out  output  1 each  registered PWM outputs
duty0 / duty1 / duty2  output  CNT_W each  current (pre-shadow) duty registers
err  output  3  sticky illegal-transition flag, bit i = channel i

Behaviour:
- Reset (reset=0, async): sync flops, prev state, PWM counter, pwm*_out, and err go to 0; duty* and shadow registers go to DUTY_INIT; startup counter goes to 0. Takes effect immediately, mid-period or mid-transition.
- Sync: each A/B passes through 2 flops (s1, s2). State {a,b} = s2.
- Startup: for the first 3 rising edges after reset deasserts, prev <= s2 with no count and no error. Decode is enabled from the 4th edge on.
- Decode, each edge when enabled, comparing prev to s2:
  - Forward sequence 00->10->11->01->00: duty += STEP, saturating at 2^CNT_W-1.
  - Reverse sequence 00->01->11->10->00: duty -= STEP, saturating at 0; compute with an extra bit, never wrap.
  - No change: hold.
  - Both bits change (00<->11, 10<->01): duty holds and err[i] <= 1. err is cleared only by reset.
  - prev <= s2 on every enabled edge.
- Latency: an input change set up before edge k updates duty on edge k+2.
- PWM counter cnt is shared by all channels, free-running 0..2^CNT_W-1, and wraps to 0.
- Shadow update: on the edge where cnt == 2^CNT_W-1, shadow_i <= duty_i. This includes a duty value updated on that same edge only if it was already registered before the edge; the pre-edge value is used.
- Output: pwm_i_out <= (cnt < shadow_i) every edge. pwm_i_out is high for exactly shadow_i cycles per 2^CNT_W-cycle period. shadow = 0 gives constant 0; the maximum duty gives low for 1 cycle per period.
- Channels are fully independent; simultaneous events on different channels have no interaction.
- No backpressure and no handshake. Encoder transitions faster than one per clk cycle after sync are out of spec and may be decoded as illegal.

Test Plan:
1. Release reset with enc0 = 11 held -> no err, duty0 = DUTY_INIT (0), pwm0_out stays 0 for all periods.
2. Forward 4-step sequence on enc0 (00,10,11,01,00), each state held 4 cycles -> duty0 = 4, 2 edges after the last change. From the next period start, pwm0_out is high exactly 4 of 256 cycles. duty1 and duty2 are unchanged.
3. Reverse sequence on enc1 from duty 0 -> duty1 stays 0 (saturate). Then 300 forward steps -> duty1 = 255, and pwm1_out is low exactly 1 cycle per period.
4. Drive enc2 00->11 in one cycle -> err = 3'b100, duty2 unchanged. A subsequent legal step still counts, and err stays set.
5. Change duty0 mid-period (cnt = 100) -> pwm0_out width in the current period uses the old shadow; the new width appears from cnt = 0 of the next period with no runt pulse.
6. Assert reset at cnt = 50 while pwm0_out = 1 -> pwm0_out = 0, err = 0, and duty* = DUTY_INIT immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/enc_pwm_ctrl.sv
// Three-channel quadrature-encoder to PWM duty controller.
// Ports: clk, reset (async low), encN_a/b in; pwmN_out, dutyN, err out.
module enc_pwm_ctrl #(
  parameter int CNT_W     = 8,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc0_a,
  input  logic             enc0_b,
  input  logic             enc1_a,
  input  logic             enc1_b,
  input  logic             enc2_a,
  input  logic             enc2_b,
  output logic             pwm0_out,
  output logic             pwm1_out,
  output logic             pwm2_out,
  output logic [CNT_W-1:0] duty0,
  output logic [CNT_W-1:0] duty1,
  output logic [CNT_W-1:0] duty2,
  output logic [2:0]       err
);

  localparam logic [CNT_W-1:0] DINIT  = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] MAX    = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP);

  logic [2:0]       a_in;
  logic [2:0]       b_in;
  logic [2:0]       a_s1_q;
  logic [2:0]       a_s2_q;
  logic [2:0]       b_s1_q;
  logic [2:0]       b_s2_q;
  logic [1:0]       prev_q   [3];
  logic [CNT_W-1:0] duty_q   [3];
  logic [CNT_W-1:0] duty_d   [3];
  logic [CNT_W-1:0] shadow_q [3];
  logic [CNT_W:0]   up_w     [3];
  logic [CNT_W:0]   dn_w     [3];
  logic [1:0]       dir_w    [3];
  logic [2:0]       err_q;
  logic [2:0]       err_d;
  logic [2:0]       pwm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       start_q;
  logic             dec_en;

  assign a_in = {enc2_a, enc1_a, enc0_a};
  assign b_in = {enc2_b, enc1_b, enc0_b};

  // Three startup edges only track state, so the
  // cleared sync flops never decode as a step.
  assign dec_en = (start_q == 2'd3);

  // Position along the forward gray sequence
  // 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gpos(
    input logic [1:0] s
  );
    logic [1:0] p;
    unique case (s)
      2'b00: p = 2'd0;
      2'b10: p = 2'd1;
      2'b11: p = 2'd2;
      2'b01: p = 2'd3;
    endcase
    return p;
  endfunction

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 3; i++) begin
      duty_d[i] = duty_q[i];
      up_w[i]   = {1'b0, duty_q[i]} + STEP_W;
      dn_w[i]   = {1'b0, duty_q[i]} - STEP_W;
      // +1 forward, -1 (3) reverse, 2 both bits moved.
      dir_w[i]  = gpos({a_s2_q[i], b_s2_q[i]})
                - gpos(prev_q[i]);
      if (dec_en) begin
        unique case (dir_w[i])
          2'd1: begin
            if (up_w[i][CNT_W]) duty_d[i] = MAX;
            else duty_d[i] = up_w[i][CNT_W-1:0];
          end
          2'd3: begin
            if (dn_w[i][CNT_W]) duty_d[i] = '0;
            else duty_d[i] = dn_w[i][CNT_W-1:0];
          end
          2'd2: err_d[i] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_s1_q  <= '0;
      a_s2_q  <= '0;
      b_s1_q  <= '0;
      b_s2_q  <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      pwm_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        prev_q[i]   <= '0;
        duty_q[i]   <= DINIT;
        shadow_q[i] <= DINIT;
      end
    end else begin
      a_s1_q <= a_in;
      a_s2_q <= a_s1_q;
      b_s1_q <= b_in;
      b_s2_q <= b_s1_q;
      if (!dec_en) start_q <= start_q + 2'd1;
      cnt_q <= cnt_q + ONE;
      err_q <= err_d;
      for (int i = 0; i < 3; i++) begin
        prev_q[i] <= {a_s2_q[i], b_s2_q[i]};
        duty_q[i] <= duty_d[i];
        // Last count of the period: latch the
        // pre-edge duty so the next period is clean.
        if (cnt_q == MAX) shadow_q[i] <= duty_q[i];
        pwm_q[i] <= (cnt_q < shadow_q[i]);
      end
    end
  end

  assign pwm0_out = pwm_q[0];
  assign pwm1_out = pwm_q[1];
  assign pwm2_out = pwm_q[2];
  assign duty0    = duty_q[0];
  assign duty1    = duty_q[1];
  assign duty2    = duty_q[2];
  assign err      = err_q;

endmodule

// File: tb/tb_enc_pwm_ctrl.sv
// Scoreboard bench for enc_pwm_ctrl.
// Stimulus queues expectations by cycle; monitor checks them.
module tb_enc_pwm_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] ea;
  logic [2:0] eb;
  logic       pwm0;
  logic       pwm1;
  logic       pwm2;
  logic [7:0] duty0;
  logic [7:0] duty1;
  logic [7:0] duty2;
  logic [2:0] err;

  enc_pwm_ctrl #(
    .CNT_W(8), .STEP(1), .DUTY_INIT(0)
  ) dut (
    .clk(clk), .reset(rst),
    .enc0_a(ea[0]), .enc0_b(eb[0]),
    .enc1_a(ea[1]), .enc1_b(eb[1]),
    .enc2_a(ea[2]), .enc2_b(eb[2]),
    .pwm0_out(pwm0), .pwm1_out(pwm1),
    .pwm2_out(pwm2),
    .duty0(duty0), .duty1(duty1),
    .duty2(duty2), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    string name;
    int    sel;
    int    due;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int hi[3];
  int lastw[3];
  logic [1:0] cur[3];

  task automatic push(string n, int s, int d, int e);
    exp_t x;
    x.name = n; x.sel = s; x.due = d; x.exp = e;
    sb.push_back(x);
  endtask

  function automatic int observe(int s);
    case (s)
      0: return int'(duty0);
      1: return int'(duty1);
      2: return int'(duty2);
      3: return int'(err);
      4: return lastw[0];
      5: return lastw[1];
      6: return lastw[2];
      7: return int'(pwm0);
      8: return int'(pwm1);
      default: return int'(pwm2);
    endcase
  endfunction

  initial begin
    for (int c = 0; c < 3; c++) begin
      hi[c] = 0;
      lastw[c] = -1;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < 3; c++) hi[c] = 0;
      end else if (cyc > 0) begin
        hi[0] += int'(pwm0);
        hi[1] += int'(pwm1);
        hi[2] += int'(pwm2);
        if (cyc % 256 == 0)
          for (int c = 0; c < 3; c++) begin
            lastw[c] = hi[c];
            hi[c] = 0;
          end
      end
      for (int k = 0; k < sb.size();) begin
        if (sb[k].due <= cyc) begin
          int act;
          act = observe(sb[k].sel);
          n_chk++;
          if (act != sb[k].exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d want %0d",
                     sb[k].name, sb[k].due, act,
                     sb[k].exp);
          end
          sb.delete(k);
        end else begin
          k++;
        end
      end
    end
  end

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_enc(int ch, logic [1:0] v);
    cur[ch] = v;
    ea[ch]  = v[1];
    eb[ch]  = v[0];
  endtask

  task automatic step_fwd(int ch);
    case (cur[ch])
      2'b00: set_enc(ch, 2'b10);
      2'b10: set_enc(ch, 2'b11);
      2'b11: set_enc(ch, 2'b01);
      default: set_enc(ch, 2'b00);
    endcase
  endtask

  task automatic step_rev(int ch);
    case (cur[ch])
      2'b00: set_enc(ch, 2'b01);
      2'b01: set_enc(ch, 2'b11);
      2'b11: set_enc(ch, 2'b10);
      default: set_enc(ch, 2'b00);
    endcase
  endtask

  initial begin
    for (int c = 0; c < 3; c++) set_enc(c, 2'b11);
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    push("duty0_rst", 0, 1, 0);
    push("err_rst", 3, 1, 0);
    push("err_startup", 3, 10, 0);
    push("duty0_idle", 0, 100, 0);
    push("w0_idle_p1", 4, 256, 0);
    push("w1_idle_p1", 5, 256, 0);
    push("w2_idle_p1", 6, 256, 0);
    push("w0_idle_p2", 4, 512, 0);

    wait_cyc(600); step_rev(0);
    wait_cyc(604); step_rev(0);
    push("duty0_rev_sat", 0, 610, 0);
    wait_cyc(608); step_fwd(0);
    push("duty0_fwd1", 0, 611, 1);
    wait_cyc(612); step_fwd(0);
    wait_cyc(616); step_fwd(0);
    wait_cyc(620); step_fwd(0);
    push("duty0_pre_last", 0, 622, 3);
    push("duty0_fwd4", 0, 623, 4);
    push("duty1_indep", 1, 624, 0);
    push("duty2_indep", 2, 624, 0);
    push("w0_old_shadow", 4, 768, 0);
    push("w0_four", 4, 1024, 4);

    wait_cyc(1030); step_rev(1);
    push("duty1_rev_sat", 1, 1042, 0);
    wait_cyc(1032); step_rev(1);
    wait_cyc(1034); step_rev(1);
    wait_cyc(1036); step_rev(1);
    push("duty1_100", 1, 1246, 100);
    push("w1_shadow117", 5, 1536, 117);
    push("duty1_sat255", 1, 1650, 255);
    push("err_clean", 3, 1650, 0);
    push("w1_max", 5, 2048, 255);
    for (int j = 0; j < 300; j++) begin
      wait_cyc(1044 + 2 * j);
      step_fwd(1);
    end

    wait_cyc(2050); set_enc(2, 2'b00);
    push("err_illegal", 3, 2054, 4);
    push("duty2_hold", 2, 2054, 0);
    wait_cyc(2056); step_fwd(2);
    push("duty2_after_err", 2, 2060, 1);
    push("err_sticky", 3, 2060, 4);
    push("w2_one", 6, 2560, 1);

    wait_cyc(2145); step_fwd(0); step_rev(1);
    wait_cyc(2147); step_fwd(0); step_rev(1);
    push("duty0_mid", 0, 2151, 6);
    push("duty1_mid", 1, 2151, 253);
    push("w0_cur_old", 4, 2304, 4);
    push("w1_cur_old", 5, 2304, 255);
    push("w0_next_new", 4, 2560, 6);
    push("w1_next_new", 5, 2560, 253);
    push("w0_hold6", 4, 2816, 6);

    for (int j = 0; j < 60; j++) begin
      wait_cyc(2570 + 2 * j);
      step_fwd(0);
    end
    push("duty0_66", 0, 2700, 66);
    push("pwm0_high", 7, 2865, 1);
    push("err_pre_rst", 3, 2865, 4);
    wait_cyc(2866);
    rst = 1'b0;
    push("pwm0_async_rst", 7, -1, 0);
    push("pwm1_async_rst", 8, -1, 0);
    push("err_async_rst", 3, -1, 0);
    push("duty0_async_rst", 0, -1, 0);
    push("duty1_async_rst", 1, -1, 0);
    push("duty2_async_rst", 2, -1, 0);
    #1;
    n_chk++;
    if (pwm0 !== 1'b0) begin
      n_fail++;
      $display("FAIL pwm0_imm_rst: got %b", pwm0);
    end
    n_chk++;
    if (err !== 3'b000) begin
      n_fail++;
      $display("FAIL err_imm_rst: got %b", err);
    end
    n_chk++;
    if (duty0 !== 8'd0) begin
      n_fail++;
      $display("FAIL duty0_imm_rst: got %0d", duty0);
    end
    n_chk++;
    if (duty1 !== 8'd0) begin
      n_fail++;
      $display("FAIL duty1_imm_rst: got %0d", duty1);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push("err_post_rst", 3, 8, 0);
    push("duty0_post_rst", 0, 8, 0);
    push("w0_post_rst", 4, 256, 0);

    for (int t = 0; t < 2000 && sb.size() > 0; t++)
      @(posedge clk);
    while (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: never checked, want %0d",
               sb[0].name, sb[0].exp);
      sb.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
